// File: rtl/led_pattern_sched_if.sv
// rtl/led_pattern_sched_if.sv - control and status bundle for the LED pattern scheduler
interface led_pattern_sched_if;
    logic       mode_next;
    logic       auto_en;
    logic       ext_req;
    logic [7:0] ext_pattern;
    logic       ext_gnt;
    logic [7:0] led_out;
    logic [1:0] mode;
    logic       step_tick;

    modport master (
        output mode_next, auto_en, ext_req, ext_pattern,
        input  ext_gnt, led_out, mode, step_tick
    );

    modport slave (
        input  mode_next, auto_en, ext_req, ext_pattern,
        output ext_gnt, led_out, mode, step_tick
    );
endinterface

// File: rtl/led_pattern_sched.sv
// rtl/led_pattern_sched.sv - built-in LED pattern sequencer with external pattern override
module led_pattern_sched #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int STEP_DIV    = CLK_FREQ / 4,
    parameter int DWELL_STEPS = 32
) (
    input logic                sys_clk,
    input logic                rst,
    led_pattern_sched_if.slave bus
);
    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int DW = (DWELL_STEPS > 1) ? $clog2(DWELL_STEPS) : 1;
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_DIV - 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_STEPS - 1);
    localparam logic [7:0]    PAT_HOME   = 8'b1111_1110;
    localparam logic [7:0]    PAT_BLINK  = 8'h00;

    typedef enum logic [1:0] {
        S_FLOW   = 2'd0,
        S_BOUNCE = 2'd1,
        S_BLINK  = 2'd2,
        S_EXT    = 2'd3
    } state_t;

    state_t        state, state_nxt;
    state_t        ret_mode, ret_nxt;
    logic [SW-1:0] step_cnt, step_nxt;
    logic [DW-1:0] dwell_cnt, dwell_nxt;
    logic [7:0]    led_r, led_nxt;
    logic          dir_left, dir_nxt;
    logic          gnt_r, gnt_nxt;
    logic          tick_r;
    logic          dwell_done;

    function automatic logic [7:0] init_pattern(input state_t m);
        return (m == S_BLINK) ? PAT_BLINK : PAT_HOME;
    endfunction

    function automatic state_t next_builtin(input state_t m);
        case (m)
            S_FLOW:   return S_BOUNCE;
            S_BOUNCE: return S_BLINK;
            default:  return S_FLOW;
        endcase
    endfunction

    assign dwell_done = bus.auto_en && tick_r && (dwell_cnt == DWELL_LAST);

    // Mode state register
    always_ff @(posedge sys_clk) begin
        if (rst) state <= S_FLOW;
        else     state <= state_nxt;
    end

    // Next mode plus pattern, counter, ownership; grant beats any mode advance
    always_comb begin
        state_nxt = state;
        ret_nxt   = ret_mode;
        led_nxt   = led_r;
        dir_nxt   = dir_left;
        gnt_nxt   = gnt_r;
        dwell_nxt = dwell_cnt;
        step_nxt  = (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;

        if (state == S_EXT) begin
            if (bus.ext_req) begin
                led_nxt = bus.ext_pattern;
            end else begin
                state_nxt = ret_mode;
                led_nxt   = init_pattern(ret_mode);
                dir_nxt   = 1'b1;
                gnt_nxt   = 1'b0;
                step_nxt  = '0;
                dwell_nxt = '0;
            end
        end else if (tick_r && bus.ext_req) begin
            state_nxt = S_EXT;
            ret_nxt   = state;
            gnt_nxt   = 1'b1;
        end else if (bus.mode_next || dwell_done) begin
            state_nxt = next_builtin(state);
            led_nxt   = init_pattern(next_builtin(state));
            dir_nxt   = 1'b1;
            step_nxt  = '0;
            dwell_nxt = '0;
        end else if (tick_r) begin
            dwell_nxt = dwell_cnt + 1'b1;
            case (state)
                S_FLOW: led_nxt = {led_r[6:0], led_r[7]};
                S_BOUNCE: begin
                    if (dir_left) begin
                        if (led_r == 8'b0111_1111) begin
                            led_nxt = 8'b1011_1111;
                            dir_nxt = 1'b0;
                        end else begin
                            led_nxt = {led_r[6:0], led_r[7]};
                        end
                    end else begin
                        if (led_r == 8'b1111_1110) begin
                            led_nxt = 8'b1111_1101;
                            dir_nxt = 1'b1;
                        end else begin
                            led_nxt = {led_r[0], led_r[7:1]};
                        end
                    end
                end
                S_BLINK: led_nxt = ~led_r;
                default: led_nxt = led_r;
            endcase
        end

        if (!bus.auto_en) dwell_nxt = '0;
    end

    // Datapath registers; step_tick is pre-decoded so it is high while the counter sits at its last value
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            ret_mode  <= S_FLOW;
            led_r     <= PAT_HOME;
            dir_left  <= 1'b1;
            gnt_r     <= 1'b0;
            step_cnt  <= '0;
            dwell_cnt <= '0;
            tick_r    <= 1'b0;
        end else begin
            ret_mode  <= ret_nxt;
            led_r     <= led_nxt;
            dir_left  <= dir_nxt;
            gnt_r     <= gnt_nxt;
            step_cnt  <= step_nxt;
            dwell_cnt <= dwell_nxt;
            tick_r    <= (step_nxt == STEP_LAST);
        end
    end

    assign bus.led_out   = led_r;
    assign bus.mode      = state;
    assign bus.ext_gnt   = gnt_r;
    assign bus.step_tick = tick_r;
endmodule

// File: tb/tb_led_pattern_sched.sv
// tb/tb_led_pattern_sched.sv - scoreboard bench for led_pattern_sched
module tb_led_pattern_sched;
    localparam int SD = 4;
    localparam int DS = 3;

    logic sys_clk = 1'b0;
    logic rst;
    always #5 sys_clk = ~sys_clk;

    led_pattern_sched_if bus ();

    led_pattern_sched #(
        .CLK_FREQ   (16),
        .STEP_DIV   (SD),
        .DWELL_STEPS(DS)
    ) dut (
        .sys_clk(sys_clk),
        .rst    (rst),
        .bus    (bus)
    );

    typedef struct {
        logic [7:0] led;
        logic [1:0] mode;
        logic       gnt;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model: mode, steps taken since entering the mode, cycles since the step phase restarted
    int         m_mode, m_ret, m_k, m_phase, m_dwell;
    bit         m_gnt;
    logic [7:0] m_ext_led;

    function automatic logic [7:0] pat(input int mode, input int k);
        logic [7:0] one;
        int p, pos;
        one = 8'h01;
        case (mode)
            0: return ~(one << (k % 8));
            1: begin
                p   = k % 14;
                pos = (p <= 7) ? p : 14 - p;
                return ~(one << pos);
            end
            default: return (k % 2 == 1) ? 8'hFF : 8'h00;
        endcase
    endfunction

    task automatic drive(input bit r, input bit mn, input bit ae, input bit er, input logic [7:0] ep);
        exp_t e;
        bit   tick;
        @(negedge sys_clk);
        rst             = r;
        bus.mode_next   = mn;
        bus.auto_en     = ae;
        bus.ext_req     = er;
        bus.ext_pattern = ep;
        tick = (m_phase == SD - 1);
        if (r) begin
            m_mode = 0; m_ret = 0; m_k = 0; m_phase = 0; m_dwell = 0; m_gnt = 0;
        end else if (m_mode == 3) begin
            if (er) begin
                m_ext_led = ep;
                m_phase   = (m_phase + 1) % SD;
            end else begin
                m_mode = m_ret; m_k = 0; m_phase = 0; m_dwell = 0; m_gnt = 0;
            end
        end else if (tick && er) begin
            m_ret     = m_mode;
            m_ext_led = pat(m_mode, m_k);
            m_mode    = 3;
            m_gnt     = 1;
            m_phase   = (m_phase + 1) % SD;
        end else if (mn || (ae && tick && m_dwell == DS - 1)) begin
            m_mode = (m_mode + 1) % 3; m_k = 0; m_phase = 0; m_dwell = 0;
        end else begin
            m_phase = (m_phase + 1) % SD;
            if (tick) begin
                m_k++;
                m_dwell++;
            end
        end
        if (!ae) m_dwell = 0;
        e.led  = (m_mode == 3) ? m_ext_led : pat(m_mode, m_k);
        e.mode = 2'(m_mode);
        e.gnt  = m_gnt;
        e.tick = (m_phase == SD - 1);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n, input bit ae);
        repeat (n) drive(1'b0, 1'b0, ae, 1'b0, 8'h00);
    endtask

    // Monitor: one expectation per clock edge, sampled just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge sys_clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.led_out !== e.led || bus.mode !== e.mode ||
                    bus.ext_gnt !== e.gnt || bus.step_tick !== e.tick) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got led=%h mode=%0d gnt=%b tick=%b, expected led=%h mode=%0d gnt=%b tick=%b",
                             cyc, bus.led_out, bus.mode, bus.ext_gnt, bus.step_tick,
                             e.led, e.mode, e.gnt, e.tick);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bit ae, er;
        rst = 1'b1;
        bus.mode_next = 1'b0; bus.auto_en = 1'b0; bus.ext_req = 1'b0; bus.ext_pattern = 8'h00;
        m_mode = 0; m_ret = 0; m_k = 0; m_phase = 0; m_dwell = 0; m_gnt = 0; m_ext_led = 8'h00;

        // free-running FLOW after reset
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        idle(40, 1'b0);

        // BOUNCE through both turnarounds
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        idle(64, 1'b0);

        // auto-cycling from reset
        drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        idle(70, 1'b1);

        // external ownership taken in BLINK
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        idle(3, 1'b0);
        repeat (12) drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h5A);
        idle(10, 1'b0);

        // grant and mode_next on the same step boundary in FLOW
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8 && m_phase != SD - 1; i++) idle(1, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C);
        repeat (8) drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h3C);
        idle(10, 1'b0);

        // reset while the external source owns the LEDs
        for (int i = 0; i < 10 && !m_gnt; i++) drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hA5);
        idle(6, 1'b0);

        // randomized traffic
        ae = 1'b0;
        er = 1'b0;
        repeat (3000) begin
            if ($urandom_range(49) == 0) ae = ~ae;
            if ($urandom_range(14) == 0) er = ~er;
            drive(($urandom_range(199) == 0), ($urandom_range(9) == 0), ae, er, 8'($urandom));
        end

        repeat (2) @(negedge sys_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
